// File: rtl/noc_packet_injector.sv
// Transmit endpoint of the mesh NoC phit link: takes a whole packet in one
// handshake and serializes it LSB-phit-first as head/body/tail flits.
module noc_packet_injector #(
   parameter int DATA_WIDTH    = 8,
   parameter int PhitPerFlit   = 2,
   parameter int FlitPerPacket = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        pkt_valid,
   output logic                                        pkt_ready,
   input  logic [FlitPerPacket*PhitPerFlit*DATA_WIDTH-1:0] pkt_data,
   output logic [DATA_WIDTH-1:0]                       data_out,
   output logic                                        valid_out,
   input  logic                                        ready_out,
   output logic                                        head_flit,
   output logic                                        tail_flit,
   output logic                                        busy,
   output logic [CNT_WIDTH-1:0]                        pkt_sent_count
);

   localparam int PKT_W = FlitPerPacket * PhitPerFlit * DATA_WIDTH;
   localparam int PW    = $clog2(PhitPerFlit) + 1;
   localparam int FW    = $clog2(FlitPerPacket) + 1;
   localparam logic [PW-1:0] LAST_PHIT = PW'(PhitPerFlit - 1);
   localparam logic [FW-1:0] LAST_BODY = FW'(FlitPerPacket - 2);

   typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

   state_t           state, state_nxt;
   logic [PKT_W-1:0] sreg;
   logic [PW-1:0]    phit_cnt;
   logic [FW-1:0]    flit_cnt;
   logic             accept;
   logic             hs;
   logic             flit_done;

   // Link outputs decode from state/shift register only, so ready_out never
   // reaches valid_out combinationally.
   assign pkt_ready = (state == IDLE) && !rst;
   assign accept    = pkt_valid && pkt_ready;
   assign valid_out = (state != IDLE);
   assign hs        = valid_out && ready_out;
   assign flit_done = hs && (phit_cnt == LAST_PHIT);
   assign data_out  = sreg[DATA_WIDTH-1:0];
   assign head_flit = (state == HEAD);
   assign tail_flit = (state == TAIL);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = HEAD;
         HEAD: if (flit_done) state_nxt = (FlitPerPacket > 2) ? BODY : TAIL;
         BODY: if (flit_done && (flit_cnt == LAST_BODY)) state_nxt = TAIL;
         TAIL: if (flit_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Zeros shift in from the top, so the register drains to 0 after the tail.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg     <= '0;
         phit_cnt <= '0;
         flit_cnt <= '0;
      end else if (accept) begin
         sreg     <= pkt_data;
         phit_cnt <= '0;
         flit_cnt <= '0;
      end else if (hs) begin
         sreg <= {{DATA_WIDTH{1'b0}}, sreg[PKT_W-1:DATA_WIDTH]};
         if (phit_cnt == LAST_PHIT) begin
            phit_cnt <= '0;
            flit_cnt <= flit_cnt + FW'(1);
         end else begin
            phit_cnt <= phit_cnt + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                              pkt_sent_count <= '0;
      else if ((state == TAIL) && flit_done) pkt_sent_count <= pkt_sent_count + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Bench for noc_packet_injector: a default-parameter unit and a 2-flit/1-phit
// unit with a 2-bit counter, both checked every cycle against a packet-level model.
module tb_noc_packet_injector;

   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_pv, a_pr, a_vo, a_ro, a_hf, a_tf, a_bs;
   logic [63:0] a_pd;
   logic [7:0]  a_do;
   logic [15:0] a_cnt;

   logic        b_pv, b_pr, b_vo, b_ro, b_hf, b_tf, b_bs;
   logic [15:0] b_pd;
   logic [7:0]  b_do;
   logic [1:0]  b_cnt;

   noc_packet_injector u_a (
      .clk(clk), .rst(rst), .pkt_valid(a_pv), .pkt_ready(a_pr), .pkt_data(a_pd),
      .data_out(a_do), .valid_out(a_vo), .ready_out(a_ro), .head_flit(a_hf),
      .tail_flit(a_tf), .busy(a_bs), .pkt_sent_count(a_cnt)
   );

   noc_packet_injector #(.DATA_WIDTH(8), .PhitPerFlit(1), .FlitPerPacket(2), .CNT_WIDTH(2)) u_b (
      .clk(clk), .rst(rst), .pkt_valid(b_pv), .pkt_ready(b_pr), .pkt_data(b_pd),
      .data_out(b_do), .valid_out(b_vo), .ready_out(b_ro), .head_flit(b_hf),
      .tail_flit(b_tf), .busy(b_bs), .pkt_sent_count(b_cnt)
   );

   // Packet-level model: a packet in flight is just its data plus the index
   // of the next phit to hand over.
   typedef struct {
      bit          inf;
      int          idx;
      logic [63:0] pkt;
      int          cnt;
   } mdl_t;

   mdl_t m [2];
   int nph  [2] = '{8, 2};
   int ppf  [2] = '{2, 1};
   int fpp  [2] = '{4, 2};
   int cmod [2] = '{65536, 4};

   int checks = 0;
   int failures = 0;

   task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=timeout expected=completion", tag);
   endtask

   task automatic mstep(input int k, input logic r, input logic pv, input logic ro,
                        input logic [63:0] pd);
      if (r) begin
         m[k].inf = 0; m[k].idx = 0; m[k].cnt = 0;
      end else if (m[k].inf) begin
         if (ro) begin
            m[k].idx++;
            if (m[k].idx == nph[k]) begin
               m[k].inf = 0;
               m[k].cnt = (m[k].cnt + 1) % cmod[k];
            end
         end
      end else if (pv) begin
         m[k].inf = 1; m[k].idx = 0; m[k].pkt = pd;
      end
   endtask

   task automatic chk(input int k, input logic pr, input logic vo, input logic hf,
                      input logic tf, input logic bs, input logic [7:0] d,
                      input logic [15:0] c);
      logic [7:0] ed;
      logic       eh, et;
      ed = 8'(m[k].pkt >> (m[k].idx * DW));
      eh = m[k].inf && (m[k].idx < ppf[k]);
      et = m[k].inf && (m[k].idx >= (fpp[k] - 1) * ppf[k]);
      ck($sformatf("u%0d pkt_ready", k), pr, !m[k].inf && !rst);
      ck($sformatf("u%0d valid_out", k), vo, m[k].inf);
      ck($sformatf("u%0d busy", k), bs, m[k].inf);
      ck($sformatf("u%0d head_flit idx=%0d", k, m[k].idx), hf, eh);
      ck($sformatf("u%0d tail_flit idx=%0d", k, m[k].idx), tf, et);
      if (m[k].inf) ck($sformatf("u%0d data_out idx=%0d", k, m[k].idx), d, ed);
      ck($sformatf("u%0d pkt_sent_count", k), c, m[k].cnt);
   endtask

   // One clock: model advances on the edge, outputs are compared at negedge.
   task automatic cyc();
      @(posedge clk);
      mstep(0, rst, a_pv, a_ro, a_pd);
      mstep(1, rst, b_pv, b_ro, {48'b0, b_pd});
      @(negedge clk);
      chk(0, a_pr, a_vo, a_hf, a_tf, a_bs, a_do, a_cnt);
      chk(1, b_pr, b_vo, b_hf, b_tf, b_bs, b_do, {14'b0, b_cnt});
   endtask

   logic [63:0] p1, p2;
   logic [7:0]  bp_exp [11] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03,
                                8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
   int          wrap_exp [5] = '{1, 2, 3, 0, 1};

   initial begin
      for (int k = 0; k < 2; k++) begin
         m[k].inf = 0; m[k].idx = 0; m[k].pkt = '0; m[k].cnt = 0;
      end
      rst = 1; a_pv = 0; a_ro = 0; a_pd = '0; b_pv = 0; b_ro = 0; b_pd = '0;
      @(negedge clk);
      cyc(); cyc();
      ck("rst a data_out", a_do, 0);
      ck("rst b data_out", b_do, 0);
      ck("rst a pkt_ready low", a_pr, 0);
      rst = 0;
      #1 ck("a pkt_ready after rst", a_pr, 1);

      // Single packet, full throughput
      a_pd = 64'h0807060504030201; a_pv = 1; a_ro = 1;
      cyc();
      a_pv = 0;
      for (int i = 0; i < 8; i++) begin
         ck($sformatf("single data %0d", i), a_do, 64'(i + 1));
         ck($sformatf("single head %0d", i), a_hf, (i < 2));
         ck($sformatf("single tail %0d", i), a_tf, (i >= 6));
         ck($sformatf("single valid %0d", i), a_vo, 1);
         cyc();
      end
      ck("single idle valid", a_vo, 0);
      ck("single idle ready", a_pr, 1);
      ck("single count", a_cnt, 1);

      // Backpressure in cycles 3..5
      a_pv = 1;
      cyc();
      a_pv = 0;
      for (int c = 1; c <= 11; c++) begin
         ck($sformatf("bp data cyc%0d", c), a_do, bp_exp[c-1]);
         a_ro = !(c >= 3 && c <= 5);
         cyc();
      end
      ck("bp done valid", a_vo, 0);
      ck("bp count", a_cnt, 2);

      // Back-to-back with pkt_valid held high, random ready_out
      p1 = {$urandom, $urandom}; p2 = ~p1;
      a_pd = p1; a_pv = 1;
      for (int n = 0; n <= 200; n++) begin
         if (m[0].cnt == 4) break;
         if (n == 200) fail_now("b2b completion");
         else begin
            if (m[0].inf && m[0].pkt == p1) a_pd = p2;
            if (m[0].inf && m[0].pkt == p2) a_pv = 0;
            a_ro = ($urandom_range(0, 3) != 0);
            cyc();
         end
      end
      a_pv = 0;
      ck("b2b count", a_cnt, 4);

      // Reset mid-packet, after the handshake of phit 04
      a_ro = 1; a_pd = 64'h1817161514131211; a_pv = 1;
      cyc();
      a_pv = 0;
      cyc(); cyc(); cyc(); cyc();
      ck("midrst data before", a_do, 8'h15);
      rst = 1;
      cyc();
      ck("midrst valid", a_vo, 0);
      ck("midrst tail", a_tf, 0);
      ck("midrst count", a_cnt, 0);
      rst = 0;
      p1 = {$urandom, $urandom};
      a_pd = p1; a_pv = 1;
      cyc();
      a_pv = 0;
      ck("midrst new head", a_hf, 1);
      ck("midrst new phit0", a_do, p1[7:0]);
      for (int n = 0; n < 8; n++) cyc();
      ck("midrst new count", a_cnt, 1);

      // Short packets and counter wrap on the second unit
      b_ro = 1;
      for (int p = 0; p < 5; p++) begin
         b_pd = 16'($urandom); b_pv = 1;
         cyc();
         b_pv = 0;
         ck($sformatf("wrap head p%0d", p), b_hf, 1);
         cyc();
         ck($sformatf("wrap tail p%0d", p), b_tf, 1);
         cyc();
         ck($sformatf("wrap count p%0d", p), b_cnt, wrap_exp[p]);
      end

      // Random traffic on both units; pkt_data changes freely while busy
      for (int n = 0; n < 600; n++) begin
         a_pv = $urandom_range(0, 1); a_pd = {$urandom, $urandom};
         a_ro = ($urandom_range(0, 3) != 0);
         b_pv = $urandom_range(0, 1); b_pd = 16'($urandom);
         b_ro = $urandom_range(0, 1);
         if (n == 300) rst = 1;
         else rst = 0;
         cyc();
      end
      rst = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Transmit-side endpoint of the mesh NoC phit link.
- Accepts one whole packet per handshake from a local core or traffic generator, then serializes it onto the link as FlitPerPacket flits of PhitPerFlit phits each, using the valid/ready protocol.
- Drives a router input port. The head flit (flit 0) carries routing info and is consumed by that port's head-flit buffer; the tail flit releases the reserved path.

Parameters:
- DATA_WIDTH, 8, phit width in bits.
- PhitPerFlit, 2, phits per flit; legal range ≥1.
- FlitPerPacket, 4, flits per packet, including head and tail; legal range ≥2.
- CNT_WIDTH, 16, width of the sent-packet counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- pkt_valid  input  1  local side offers a packet.
- pkt_ready  output  1  injector can take a packet.
- pkt_data  input  FlitPerPacket*PhitPerFlit*DATA_WIDTH  whole packet; phit k is bits [k*DATA_WIDTH +: DATA_WIDTH]; phits 0..PhitPerFlit-1 form the head flit.
- data_out  output  DATA_WIDTH  current phit to the router.
- valid_out  output  1  data_out is valid.
- ready_out  input  1  router accepts the phit.
- head_flit  output  1  current phit belongs to the head flit.
- tail_flit  output  1  current phit belongs to the tail flit.
- busy  output  1  a packet is in flight.
- pkt_sent_count  output  CNT_WIDTH  number of fully transmitted packets.

Behaviour:
- Reset rst is synchronous and active-high; clock clk. After a rst edge:
  - state=IDLE, valid_out=0, data_out=0, head_flit=0, tail_flit=0, busy=0, pkt_sent_count=0.
  - pkt_ready=1 from the first cycle rst is low.
- A rst asserted mid-packet discards the packet. valid_out is 0 in the cycle after the rst edge. No partial tail is ever sent.
- pkt_ready = (state==IDLE) && !rst. A packet is accepted when pkt_valid && pkt_ready at a clk edge; pkt_data is captured into an internal shift register.
- FSM states:
  - IDLE: on accept, go to HEAD. phit_cnt=0, flit_cnt=0.
  - HEAD: sending flit 0. On the link handshake of the last phit (phit_cnt==PhitPerFlit-1), go to BODY if FlitPerPacket>2, else go to TAIL.
  - BODY: sending flits 1..FlitPerPacket-2. On the last-phit handshake of flit FlitPerPacket-2, go to TAIL.
  - TAIL: sending flit FlitPerPacket-1. On its last-phit handshake, go to IDLE and increment pkt_sent_count (wraps modulo 2^CNT_WIDTH).
- Link handshake = valid_out && ready_out.
  - valid_out=1 in HEAD/BODY/TAIL and is never conditioned on ready_out. The sender asserts valid first; the router answers with ready.
  - While valid_out=1 and ready_out=0, data_out, head_flit and tail_flit stay stable.
  - Each handshake advances exactly one phit: the shift register shifts right by DATA_WIDTH; phit_cnt increments and wraps to 0 at PhitPerFlit, and flit_cnt increments on that wrap.
- data_out is the low DATA_WIDTH bits of the shift register. Phit order is 0,1,2,… (LSB first), matching the receiver's phitCounter indexing.
- head_flit = (state==HEAD); tail_flit = (state==TAIL); busy = (state!=IDLE).
- Latency: packet accepted at edge N; first phit valid in cycle N+1. With ready_out held at 1, the packet occupies FlitPerPacket*PhitPerFlit consecutive cycles.
- There is at least one idle cycle between packets. pkt_ready rises in the cycle after the final handshake, so the next packet's head starts 2 cycles after the previous tail's last handshake.
- pkt_valid while busy is ignored; the packet is not accepted and pkt_data is not sampled.
- ready_out while valid_out=0 has no effect.
- Counter widths:
  - phit_cnt: $clog2(PhitPerFlit)+1 bits.
  - flit_cnt: $clog2(FlitPerPacket)+1 bits.
- No combinational path from ready_out to valid_out. data_out/valid_out are registered or decoded from state only.

Test Plan:
- Single packet, defaults, ready_out=1, pkt_data=64'h0807060504030201, accepted at edge 0 → cycles 1..8: valid_out=1, data_out=01..08; head_flit=1 on 01,02; tail_flit=1 on 07,08; cycle 9: valid_out=0, pkt_ready=1; pkt_sent_count=1.
- Backpressure: same packet, ready_out=0 in cycles 3–5 → data_out holds 03 for cycles 3–6 (released by ready_out=1 in cycle 6), 04 in cycle 7, last phit 08 in cycle 11, no phit dropped or duplicated.
- Back-to-back: pkt_valid held high with two packets → pkt_ready=0 during the first packet; the second is accepted 1 cycle after the first tail handshake; its first phit appears 2 cycles after that handshake, with head_flit=1.
- Reset mid-packet: rst pulsed for 1 cycle after phit 04 handshake → valid_out=0 the next cycle, pkt_sent_count unchanged (0), tail never asserted; a new packet afterwards starts at phit 0 with head_flit=1.
- Parameter sweep: FlitPerPacket=2, PhitPerFlit=1 → HEAD goes directly to TAIL, 2 phits per packet, BODY never entered.
- Counter wrap: CNT_WIDTH=2, send 5 packets → pkt_sent_count reads 1,2,3,0,1.
